// File: rtl/writeback_stage.sv
// Final pipeline stage: merges ALU results and aligned/extended load data onto the register file write port.
// Latency: 1 cycle from ALU accept or from LD_DONE to rf_we; single outstanding load tracked.
// Backpressure: alu_ready drops in LD_DONE (load write wins); ld_issue_ready only in IDLE; clk_en=0 freezes everything.
module writeback_stage #(
  parameter int RV32E = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue_valid,
  output logic        ld_issue_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  dec_rs1_addr,
  input  logic [4:0]  dec_rs2_addr,
  output logic        load_hazard,
  output logic        rf_we,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_data
);

  // RV32E has 16 registers, so only the low 4 address bits are meaningful.
  localparam int ADDRSIZE = (RV32E != 0) ? 4 : 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    LD_DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_addr_lo_q;
  logic [31:0] ld_buf;
  logic [31:0] ld_ext;
  logic        alu_fire;
  logic        ld_rd_nz;
  logic        alu_rd_nz;
  logic        rs1_hit;
  logic        rs2_hit;

  // Align the addressed byte/halfword to bit 0 and extend it per the load type.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh = word >> {addr_lo, 3'b000};
    half_sh = word >> {addr_lo[1], 4'b0000};
    case (funct3)
      3'b000:  return {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  return {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  return {24'h0, byte_sh[7:0]};
      3'b101:  return {16'h0, half_sh[15:0]};
      default: return word;
    endcase
  endfunction

  assign ld_ext    = load_extend(mem_rdata, ld_funct3_q, ld_addr_lo_q);
  assign ld_rd_nz  = |ld_rd_q[ADDRSIZE-1:0];
  assign alu_rd_nz = |alu_rd[ADDRSIZE-1:0];
  assign rs1_hit   = (dec_rs1_addr[ADDRSIZE-1:0] == ld_rd_q[ADDRSIZE-1:0]);
  assign rs2_hit   = (dec_rs2_addr[ADDRSIZE-1:0] == ld_rd_q[ADDRSIZE-1:0]);
  assign alu_fire  = alu_valid && alu_ready;

  // Load tracker next state plus handshake and hazard outputs.
  always_comb begin
    state_d        = state_q;
    ld_issue_ready = 1'b0;
    alu_ready      = 1'b1;
    load_hazard    = 1'b0;
    case (state_q)
      IDLE: begin
        ld_issue_ready = 1'b1;
        if (ld_issue_valid) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        load_hazard = ld_rd_nz && (rs1_hit || rs2_hit);
        if (mem_rvalid) state_d = LD_DONE;
      end
      LD_DONE: begin
        alu_ready   = 1'b0;
        load_hazard = ld_rd_nz && (rs1_hit || rs2_hit);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and load context capture; reset abandons any outstanding load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ld_rd_q      <= 5'd0;
      ld_funct3_q  <= 3'd0;
      ld_addr_lo_q <= 2'd0;
      ld_buf       <= 32'd0;
    end else if (clk_en) begin
      state_q <= state_d;
      if (state_q == IDLE && ld_issue_valid) begin
        ld_rd_q      <= ld_rd;
        ld_funct3_q  <= ld_funct3;
        ld_addr_lo_q <= ld_addr_lo;
      end
      if (state_q == LD_WAIT && mem_rvalid) begin
        ld_buf <= ld_ext;
      end
    end
  end

  // Register file write port: load write has priority, x0 writes are consumed but suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= 5'd0;
      rf_data    <= 32'd0;
    end else if (clk_en) begin
      if (state_q == LD_DONE) begin
        rf_we <= ld_rd_nz;
        if (ld_rd_nz) begin
          rf_rd_addr <= ld_rd_q;
          rf_data    <= ld_buf;
        end
      end else if (alu_fire) begin
        rf_we <= alu_rd_nz;
        if (alu_rd_nz) begin
          rf_rd_addr <= alu_rd;
          rf_data    <= alu_data;
        end
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a write scoreboard.
// Expected register writes are queued when stimulus is driven and popped on each rf_we.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_writeback_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  dec_rs1_addr;
  logic [4:0]  dec_rs2_addr;
  logic        load_hazard;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_data;

  int checks = 0;
  int errors = 0;
  wr_t sb[$];

  writeback_stage #(.RV32E(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_ready (ld_issue_ready),
    .ld_rd          (ld_rd),
    .ld_funct3      (ld_funct3),
    .ld_addr_lo     (ld_addr_lo),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .dec_rs1_addr   (dec_rs1_addr),
    .dec_rs2_addr   (dec_rs2_addr),
    .load_hazard    (load_hazard),
    .rf_we          (rf_we),
    .rf_rd_addr     (rf_rd_addr),
    .rf_data        (rf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every register file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_we) begin
      check("sb_write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("sb_rd", 32'(rf_rd_addr), 32'(e.rd));
        check("sb_data", rf_data, e.data);
      end
    end
  end

  // Full load round trip from IDLE, with issue fields scrambled after capture.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] rdata, input logic [31:0] exp);
    ld_issue_valid = 1'b1;
    ld_rd          = rd;
    ld_funct3      = f3;
    ld_addr_lo     = lo;
    #1;
    check({tag, "_issue_rdy_idle"}, 32'(ld_issue_ready), 32'd1);
    tick();
    ld_issue_valid = 1'b0;
    ld_rd          = 5'h1f;
    ld_funct3      = 3'b010;
    ld_addr_lo     = 2'b00;
    #1;
    check({tag, "_issue_rdy_wait"}, 32'(ld_issue_ready), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    if (rd != 5'd0) sb.push_back('{rd: rd, data: exp});
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check({tag, "_alu_rdy_done"}, 32'(alu_ready), 32'd0);
    tick();
    check({tag, "_we"}, 32'(rf_we), 32'(rd != 5'd0));
    if (rd != 5'd0) begin
      check({tag, "_addr"}, 32'(rf_rd_addr), 32'(rd));
      check({tag, "_data"}, rf_data, exp);
    end
    tick();
    check({tag, "_we_after"}, 32'(rf_we), 32'd0);
  endtask

  initial begin
    logic [4:0] hrd;
    logic       hexp;
    rst = 1'b1; clk_en = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    ld_issue_valid = 1'b0; ld_rd = 5'd0; ld_funct3 = 3'd0; ld_addr_lo = 2'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    dec_rs1_addr = 5'd0; dec_rs2_addr = 5'd0;
    tick();
    tick();
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_addr", 32'(rf_rd_addr), 32'd0);
    check("rst_data", rf_data, 32'h0);
    check("rst_issue_rdy", 32'(ld_issue_ready), 32'd1);
    check("rst_hazard", 32'(load_hazard), 32'd0);
    check("rst_alu_rdy", 32'(alu_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Plain ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("alu_rdy", 32'(alu_ready), 32'd1);
    sb.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    tick();
    alu_valid = 1'b0;
    check("alu_we", 32'(rf_we), 32'd1);
    check("alu_addr", 32'(rf_rd_addr), 32'd5);
    check("alu_data", rf_data, 32'hDEADBEEF);
    tick();
    check("alu_we_off", 32'(rf_we), 32'd0);

    // Load extension variants.
    do_load("lb",  5'd7, 3'b000, 2'd2, 32'h12805634, 32'hFFFFFF80);
    do_load("lbu", 5'd7, 3'b100, 2'd2, 32'h12805634, 32'h00000080);
    do_load("lhu", 5'd7, 3'b101, 2'd2, 32'h12805634, 32'h00001280);
    do_load("lh",  5'd6, 3'b001, 2'd3, 32'h8001AAAA, 32'hFFFF8001);
    do_load("lw",  5'd8, 3'b010, 2'd3, 32'hCAFEF00D, 32'hCAFEF00D);
    do_load("lb0", 5'd9, 3'b000, 2'd0, 32'h0000007F, 32'h0000007F);

    // Hazard tracking: rs2 match, rd=0 (never), rs1 match.
    for (int k = 0; k < 3; k++) begin
      hrd  = (k == 0) ? 5'd3 : ((k == 1) ? 5'd0 : 5'd9);
      hexp = (hrd != 5'd0);
      if (k == 2) dec_rs1_addr = hrd; else dec_rs2_addr = hrd;
      ld_issue_valid = 1'b1; ld_rd = hrd; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
      #1;
      check("hz_idle", 32'(load_hazard), 32'd0);
      tick();
      ld_issue_valid = 1'b0;
      #1;
      check("hz_wait1", 32'(load_hazard), 32'(hexp));
      tick();
      check("hz_wait2", 32'(load_hazard), 32'(hexp));
      dec_rs1_addr = 5'd1; dec_rs2_addr = 5'd2;
      #1;
      check("hz_nomatch", 32'(load_hazard), 32'd0);
      if (k == 2) dec_rs1_addr = hrd; else dec_rs2_addr = hrd;
      mem_rvalid = 1'b1; mem_rdata = 32'h000000AA;
      if (hexp) sb.push_back('{rd: hrd, data: 32'h000000AA});
      tick();
      mem_rvalid = 1'b0;
      check("hz_done", 32'(load_hazard), 32'(hexp));
      tick();
      check("hz_write", 32'(load_hazard), 32'd0);
      check("hz_write_we", 32'(rf_we), 32'(hexp));
      dec_rs1_addr = 5'd0; dec_rs2_addr = 5'd0;
      tick();
    end

    // ALU and load return together in LD_WAIT, then ALU held off in LD_DONE.
    ld_issue_valid = 1'b1; ld_rd = 5'd10; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    tick();
    ld_issue_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h11111111;
    #1;
    check("mix_alu_rdy_wait", 32'(alu_ready), 32'd1);
    sb.push_back('{rd: 5'd12, data: 32'h11111111});
    sb.push_back('{rd: 5'd10, data: 32'h0BADF00D});
    tick();
    mem_rvalid = 1'b0;
    alu_rd = 5'd13; alu_data = 32'h22222222;
    #1;
    check("mix_alu_rdy_done", 32'(alu_ready), 32'd0);
    check("mix_w1_addr", 32'(rf_rd_addr), 32'd12);
    tick();
    check("mix_w2_addr", 32'(rf_rd_addr), 32'd10);
    check("mix_alu_rdy_idle", 32'(alu_ready), 32'd1);
    sb.push_back('{rd: 5'd13, data: 32'h22222222});
    tick();
    alu_valid = 1'b0;
    check("mix_w3_addr", 32'(rf_rd_addr), 32'd13);
    check("mix_w3_data", rf_data, 32'h22222222);
    tick();

    // ALU write to x0 is consumed but not written.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    check("x0_alu_rdy", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("x0_we", 32'(rf_we), 32'd0);
    tick();

    // clk_en low freezes the write port.
    clk_en = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h5A5A5A5A;
    tick();
    check("stall_we", 32'(rf_we), 32'd0);
    clk_en = 1'b1;
    sb.push_back('{rd: 5'd14, data: 32'h5A5A5A5A});
    tick();
    alu_valid = 1'b0;
    check("stall_release_we", 32'(rf_we), 32'd1);
    tick();

    // Reset in LD_WAIT abandons the load; a late return is ignored.
    ld_issue_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    dec_rs1_addr = 5'd4;
    tick();
    ld_issue_valid = 1'b0;
    #1;
    check("abort_hz_before", 32'(load_hazard), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_issue_rdy", 32'(ld_issue_ready), 32'd1);
    check("abort_hz", 32'(load_hazard), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    tick();
    mem_rvalid = 1'b0;
    check("abort_we1", 32'(rf_we), 32'd0);
    tick();
    check("abort_we2", 32'(rf_we), 32'd0);
    dec_rs1_addr = 5'd0;
    do_load("post_rst", 5'd11, 3'b000, 2'd1, 32'h0000C300, 32'hFFFFFFC3);

    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
